// File: rtl/uart_pkg_rx_pkg.sv
// Shared definitions for the debug package stream (receive decoder and transmit packager).
// Frame: SYNC, header {kind, addr, 0}, data[31:0] MSB first, optional XOR checksum.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

package uart_pkg_rx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [KIND_W-1:0] KIND_REG   = 2'b00;
  localparam logic [KIND_W-1:0] KIND_ALU   = 2'b01;
  localparam logic [KIND_W-1:0] KIND_INST  = 2'b10;
  localparam logic [KIND_W-1:0] KIND_OTHER = 2'b11;

  localparam logic [ADDR_W-1:0] ALU_SLOT_INST   = 5'd1;
  localparam logic [ADDR_W-1:0] ALU_SLOT_REG1   = 5'd2;
  localparam logic [ADDR_W-1:0] ALU_SLOT_REG2   = 5'd3;
  localparam logic [ADDR_W-1:0] ALU_SLOT_RESULT = 5'd4;
  localparam logic [ADDR_W-1:0] OTHER_SLOT_PC   = 5'd1;
  localparam logic [ADDR_W-1:0] OTHER_SLOT_HI   = 5'd2;
  localparam logic [ADDR_W-1:0] OTHER_SLOT_LO   = 5'd3;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT    = 8'hA5;
  localparam int unsigned       BYTE_TIMEOUT_DEFAULT = 83312;

  typedef enum logic [2:0] {
    S_HUNT,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  // Header byte as placed on the wire; bit0 is reserved and must be zero.
  function automatic logic [BYTE_W-1:0] hdr_byte(input logic [KIND_W-1:0] kind,
                                                 input logic [ADDR_W-1:0] addr);
    return {kind, addr, 1'b0};
  endfunction

endpackage

// File: rtl/uart_pkg_rx_if.sv
// Byte-in / package-out bundle of the debug package receiver.
interface uart_pkg_rx_if;
  import uart_pkg_rx_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_byte;
  logic              pkt_valid;
  logic [KIND_W-1:0] pkt_kind;
  logic [ADDR_W-1:0] pkt_addr;
  logic [DATA_W-1:0] pkt_data;
  logic              pkt_err;
  logic              burst_done;
  logic [CNT_W-1:0]  good_cnt;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output rx_valid, rx_byte,
    input  pkt_valid, pkt_kind, pkt_addr, pkt_data, pkt_err, burst_done, good_cnt, err_cnt
  );

  modport slave (
    input  rx_valid, rx_byte,
    output pkt_valid, pkt_kind, pkt_addr, pkt_data, pkt_err, burst_done, good_cnt, err_cnt
  );
endinterface

// File: rtl/uart_pkg_timeout.sv
// Loadable down-counter; expired_c flags an enabled counter that has run down to zero.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

module uart_pkg_timeout #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired_c
);

  logic [WIDTH-1:0] count;

  // Load beats clear so a byte arriving as the counter idles still rearms it.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn == `RstEnable) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired_c = enable && (count == '0);

endmodule

// File: rtl/uart_pkg_rx.sv
// Debug package stream decoder: sync hunt, frame reassembly, good/error counting.
// Define PKG_RX_CHECKSUM_EN to expect a trailing XOR checksum byte on each frame.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

module uart_pkg_rx
  import uart_pkg_rx_pkg::*;
#(
  parameter int unsigned       BYTE_TIMEOUT = BYTE_TIMEOUT_DEFAULT,
  parameter logic [BYTE_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input logic          clk,
  input logic          resetn,
  uart_pkg_rx_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(BYTE_TIMEOUT + 1);
`ifdef PKG_RX_CHECKSUM_EN
  localparam int unsigned SHIFT_W = DATA_W;
`else
  localparam int unsigned SHIFT_W = DATA_W - BYTE_W;
`endif

  state_e             state;
  state_e             state_nxt;
  logic [1:0]         byte_cnt;
  logic [SHIFT_W-1:0] shift;
  logic [KIND_W-1:0]  hdr_kind;
  logic [ADDR_W-1:0]  hdr_addr;
`ifdef PKG_RX_CHECKSUM_EN
  logic [BYTE_W-1:0]  csum;
`endif

  pkt_t               pkt_q;
  logic               valid_q;
  logic               err_q;
  logic               burst_q;
  logic [CNT_W-1:0]   good_q;
  logic [CNT_W-1:0]   errs_q;

  logic               accept_c;
  logic               err_c;
  logic               hdr_load_c;
  logic               data_shift_c;
  logic [DATA_W-1:0]  data_final_c;
  logic               tmr_en_c;
  logic               tmr_exp_c;

  uart_pkg_timeout #(.WIDTH(TMR_W)) u_timeout (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (!tmr_en_c),
    .load       (bus.rx_valid),
    .load_value (TMR_W'(BYTE_TIMEOUT - 1)),
    .enable     (tmr_en_c),
    .expired_c  (tmr_exp_c)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn == `RstEnable) state <= S_HUNT;
    else                      state <= state_nxt;
  end

  // Next state and per-byte strobes; a byte on the timeout cycle takes precedence.
  always_comb begin
    state_nxt    = state;
    accept_c     = 1'b0;
    err_c        = 1'b0;
    hdr_load_c   = 1'b0;
    data_shift_c = 1'b0;
    data_final_c = {shift[DATA_W-BYTE_W-1:0], bus.rx_byte};
    tmr_en_c     = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    case (state)
      S_HUNT, S_DONE: begin
        if (bus.rx_valid && (bus.rx_byte == SYNC_BYTE)) state_nxt = S_HDR;
        else                                            state_nxt = S_HUNT;
      end
      S_HDR: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte[0]) begin
            err_c     = 1'b1;
            state_nxt = S_HUNT;
          end else begin
            hdr_load_c = 1'b1;
            state_nxt  = S_DATA;
          end
        end else if (tmr_exp_c) begin
          err_c     = 1'b1;
          state_nxt = S_HUNT;
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          data_shift_c = 1'b1;
          if (byte_cnt == 2'd3) begin
`ifdef PKG_RX_CHECKSUM_EN
            state_nxt = S_CSUM;
`else
            accept_c  = 1'b1;
            state_nxt = S_DONE;
`endif
          end
        end else if (tmr_exp_c) begin
          err_c     = 1'b1;
          state_nxt = S_HUNT;
        end
      end
`ifdef PKG_RX_CHECKSUM_EN
      S_CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == csum) begin
            accept_c     = 1'b1;
            data_final_c = shift;
            state_nxt    = S_DONE;
          end else begin
            err_c     = 1'b1;
            state_nxt = S_HUNT;
          end
        end else if (tmr_exp_c) begin
          err_c     = 1'b1;
          state_nxt = S_HUNT;
        end
      end
`endif
      default: state_nxt = S_HUNT;
    endcase
  end

  // Frame assembly and registered outputs; packet fields persist across errors.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn == `RstEnable) begin
      byte_cnt <= '0;
      shift    <= '0;
      hdr_kind <= '0;
      hdr_addr <= '0;
`ifdef PKG_RX_CHECKSUM_EN
      csum     <= '0;
`endif
      pkt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      burst_q  <= 1'b0;
      good_q   <= '0;
      errs_q   <= '0;
    end else begin
      if (hdr_load_c) begin
        hdr_kind <= bus.rx_byte[7:6];
        hdr_addr <= bus.rx_byte[5:1];
        byte_cnt <= '0;
`ifdef PKG_RX_CHECKSUM_EN
        csum     <= bus.rx_byte;
`endif
      end
      if (data_shift_c) begin
        shift    <= {shift[SHIFT_W-BYTE_W-1:0], bus.rx_byte};
        byte_cnt <= byte_cnt + 2'(1);
`ifdef PKG_RX_CHECKSUM_EN
        csum     <= csum ^ bus.rx_byte;
`endif
      end
      valid_q <= accept_c;
      err_q   <= err_c;
      burst_q <= accept_c && (hdr_kind == KIND_OTHER) && (hdr_addr == OTHER_SLOT_LO);
      if (accept_c) begin
        pkt_q.kind <= hdr_kind;
        pkt_q.addr <= hdr_addr;
        pkt_q.data <= data_final_c;
        good_q     <= good_q + CNT_W'(1);
      end
      if (err_c) errs_q <= errs_q + CNT_W'(1);
    end
  end

  assign bus.pkt_valid  = valid_q;
  assign bus.pkt_kind   = pkt_q.kind;
  assign bus.pkt_addr   = pkt_q.addr;
  assign bus.pkt_data   = pkt_q.data;
  assign bus.pkt_err    = err_q;
  assign bus.burst_done = burst_q;
  assign bus.good_cnt   = good_q;
  assign bus.err_cnt    = errs_q;

endmodule

// File: tb/tb_uart_pkg_rx.sv
// Directed bench for uart_pkg_rx: vector table of frames plus timeout, burst and reset sequences.
`timescale 1ns/1ps

module tb_uart_pkg_rx;
  import uart_pkg_rx_pkg::*;

  localparam int unsigned TB_TIMEOUT = 24;
  localparam logic [7:0]  SYNC       = 8'hA5;
  localparam logic [1:0]  M_OK       = 2'd0;
  localparam logic [1:0]  M_BADHDR   = 2'd1;
  localparam logic [1:0]  M_BADCSUM  = 2'd2;
`ifdef PKG_RX_CHECKSUM_EN
  localparam logic [1:0]  ROW2_MODE  = M_BADCSUM;
`else
  localparam logic [1:0]  ROW2_MODE  = M_BADHDR;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  uart_pkg_rx_if bus();

  uart_pkg_rx #(.BYTE_TIMEOUT(TB_TIMEOUT), .SYNC_BYTE(SYNC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_burst = 0;

  always @(negedge clk) begin
    if (bus.pkt_valid)  n_valid++;
    if (bus.pkt_err)    n_err++;
    if (bus.burst_done) n_burst++;
  end

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  ngarb;
    logic [1:0]  mode;
    logic        e_valid;
    logic        e_err;
    logic        e_burst;
    logic [1:0]  e_kind;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [15:0] e_good;
    logic [15:0] e_errc;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] garb[3];

  function automatic vec_t mk(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d,
                              input logic [1:0] ng, input logic [1:0] m, input logic ev,
                              input logic ee, input logic eb, input logic [1:0] ek,
                              input logic [4:0] ea, input logic [31:0] ed,
                              input logic [15:0] eg, input logic [15:0] ec);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.ngarb = ng; v.mode = m;
    v.e_valid = ev; v.e_err = ee; v.e_burst = eb; v.e_kind = ek; v.e_addr = ea;
    v.e_data = ed; v.e_good = eg; v.e_errc = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Sends one frame starting on a negedge; optional idle gap before data byte index gap_at (3 = MSB).
  task automatic send_frame(input logic [1:0] kind, input logic [4:0] addr, input logic [31:0] data,
                            input logic [1:0] mode, input int gap_at, input int gap_len);
    logic [7:0] hdr;
    logic [7:0] cs;
    hdr = {kind, addr, 1'b0};
    if (mode == M_BADHDR) hdr[0] = 1'b1;
    drive_byte(SYNC);
    drive_byte(hdr);
    if (mode == M_BADHDR) return;
    cs = hdr;
    for (int i = 3; i >= 0; i--) begin
      if (i == gap_at) repeat (gap_len) @(negedge clk);
      drive_byte(data[i*8 +: 8]);
      cs = cs ^ data[i*8 +: 8];
    end
`ifdef PKG_RX_CHECKSUM_EN
    if (mode == M_BADCSUM) cs = cs + 8'd1;
    drive_byte(cs);
`endif
  endtask

  task automatic check_now(input string tag, input logic ev, input logic ee, input logic eb,
                           input logic [1:0] ek, input logic [4:0] ea, input logic [31:0] ed,
                           input logic [15:0] eg, input logic [15:0] ec);
    chk({tag, ".valid"}, 32'(bus.pkt_valid), 32'(ev));
    chk({tag, ".err"},   32'(bus.pkt_err), 32'(ee));
    chk({tag, ".burst"}, 32'(bus.burst_done), 32'(eb));
    chk({tag, ".kind"},  32'(bus.pkt_kind), 32'(ek));
    chk({tag, ".addr"},  32'(bus.pkt_addr), 32'(ea));
    chk({tag, ".data"},  bus.pkt_data, ed);
    chk({tag, ".good"},  32'(bus.good_cnt), 32'(eg));
    chk({tag, ".errc"},  32'(bus.err_cnt), 32'(ec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int v0;
    int e0;
    int b0;
    logic [1:0] bk[9];
    logic [4:0] ba[9];

    garb[0] = 8'h00; garb[1] = 8'hFF; garb[2] = 8'h12;
    vecs[0] = mk(KIND_ALU,   5'd5,  32'hDEADBEEF, 2'd0, M_OK,      1, 0, 0, KIND_ALU,   5'd5, 32'hDEADBEEF, 16'd1, 16'd0);
    vecs[1] = mk(KIND_REG,   5'd3,  32'h12345678, 2'd3, M_OK,      1, 0, 0, KIND_REG,   5'd3, 32'h12345678, 16'd2, 16'd0);
    vecs[2] = mk(KIND_INST,  5'd1,  32'hCAFEF00D, 2'd0, ROW2_MODE, 0, 1, 0, KIND_REG,   5'd3, 32'h12345678, 16'd2, 16'd1);
    vecs[3] = mk(KIND_INST,  5'd1,  32'hA5A500A5, 2'd0, M_OK,      1, 0, 0, KIND_INST,  5'd1, 32'hA5A500A5, 16'd3, 16'd1);
    vecs[4] = mk(KIND_OTHER, 5'd31, 32'h0,        2'd0, M_BADHDR,  0, 1, 0, KIND_INST,  5'd1, 32'hA5A500A5, 16'd3, 16'd2);
    vecs[5] = mk(KIND_OTHER, 5'd2,  32'h0000A5A5, 2'd1, M_OK,      1, 0, 0, KIND_OTHER, 5'd2, 32'h0000A5A5, 16'd4, 16'd2);
    vecs[6] = mk(KIND_OTHER, 5'd3,  32'h00000001, 2'd0, M_OK,      1, 0, 1, KIND_OTHER, 5'd3, 32'h00000001, 16'd5, 16'd2);

    resetn       = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_now("reset", 0, 0, 0, 2'd0, 5'd0, 32'h0, 16'd0, 16'd0);
    @(negedge clk);
    resetn = 1'b0;
    settle();
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      v0 = n_valid;
      e0 = n_err;
      for (int g = 0; g < int'(vecs[r].ngarb); g++) drive_byte(garb[g]);
      send_frame(vecs[r].kind, vecs[r].addr, vecs[r].data, vecs[r].mode, -1, 0);
      check_now($sformatf("row%0d", r), vecs[r].e_valid, vecs[r].e_err, vecs[r].e_burst,
                vecs[r].e_kind, vecs[r].e_addr, vecs[r].e_data, vecs[r].e_good, vecs[r].e_errc);
      settle();
      chk($sformatf("row%0d.npkt", r), 32'(n_valid - v0), 32'(vecs[r].e_valid));
      chk($sformatf("row%0d.nerr", r), 32'(n_err - e0), 32'(vecs[r].e_err));
      @(negedge clk);
    end

    // Stall after the second data byte until the timeout fires.
    v0 = n_valid;
    drive_byte(SYNC);
    drive_byte({KIND_ALU, 5'd2, 1'b0});
    drive_byte(8'hDE);
    drive_byte(8'hAD);
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    chk("tmo.early", 32'(bus.pkt_err), 32'd0);
    @(negedge clk);
    chk("tmo.err", 32'(bus.pkt_err), 32'd1);
    settle();
    chk("tmo.errc", 32'(bus.err_cnt), 32'd3);
    chk("tmo.data_kept", bus.pkt_data, 32'h00000001);
    chk("tmo.npkt", 32'(n_valid - v0), 32'd0);
    @(negedge clk);
    send_frame(KIND_REG, 5'd7, 32'h11223344, M_OK, -1, 0);
    check_now("after_tmo", 1, 0, 0, KIND_REG, 5'd7, 32'h11223344, 16'd6, 16'd3);
    settle();

    // Idle gap one short of the timeout: the byte wins.
    @(negedge clk);
    e0 = n_err;
    send_frame(KIND_INST, 5'd4, 32'h01020304, M_OK, 1, TB_TIMEOUT - 1);
    check_now("gap_ok", 1, 0, 0, KIND_INST, 5'd4, 32'h01020304, 16'd7, 16'd3);
    settle();
    chk("gap_ok.nerr", 32'(n_err - e0), 32'd0);

    // Sync byte arriving while the previous frame is in its done cycle.
    @(negedge clk);
    v0 = n_valid;
    send_frame(KIND_ALU, 5'd1, 32'h55AA55AA, M_OK, -1, 0);
    check_now("b2b.first", 1, 0, 0, KIND_ALU, 5'd1, 32'h55AA55AA, 16'd8, 16'd3);
    send_frame(KIND_ALU, 5'd2, 32'h0F0F0F0F, M_OK, -1, 0);
    check_now("b2b.second", 1, 0, 0, KIND_ALU, 5'd2, 32'h0F0F0F0F, 16'd9, 16'd3);
    settle();
    chk("b2b.npkt", 32'(n_valid - v0), 32'd2);

    // Nine-package burst; only the OTHER/LO package closes it.
    bk[0] = KIND_REG;   ba[0] = 5'd0;
    bk[1] = KIND_ALU;   ba[1] = ALU_SLOT_INST;
    bk[2] = KIND_ALU;   ba[2] = ALU_SLOT_REG1;
    bk[3] = KIND_ALU;   ba[3] = ALU_SLOT_REG2;
    bk[4] = KIND_ALU;   ba[4] = ALU_SLOT_RESULT;
    bk[5] = KIND_INST;  ba[5] = 5'd1;
    bk[6] = KIND_OTHER; ba[6] = OTHER_SLOT_PC;
    bk[7] = KIND_OTHER; ba[7] = OTHER_SLOT_HI;
    bk[8] = KIND_OTHER; ba[8] = OTHER_SLOT_LO;
    v0 = n_valid;
    b0 = n_burst;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      send_frame(bk[i], ba[i], 32'h10000000 + 32'(i), M_OK, -1, 0);
      chk($sformatf("burst%0d.valid", i), 32'(bus.pkt_valid), 32'd1);
      chk($sformatf("burst%0d.done", i), 32'(bus.burst_done), 32'(i == 8));
      chk($sformatf("burst%0d.kind", i), 32'(bus.pkt_kind), 32'(bk[i]));
      chk($sformatf("burst%0d.addr", i), 32'(bus.pkt_addr), 32'(ba[i]));
      chk($sformatf("burst%0d.data", i), bus.pkt_data, 32'h10000000 + 32'(i));
    end
    settle();
    chk("burst.npkt", 32'(n_valid - v0), 32'd9);
    chk("burst.ndone", 32'(n_burst - b0), 32'd1);
    chk("burst.good", 32'(bus.good_cnt), 32'd18);

    // Reset asserted together with the third data byte.
    @(negedge clk);
    drive_byte(SYNC);
    drive_byte({KIND_INST, 5'd9, 1'b0});
    drive_byte(8'hAA);
    drive_byte(8'hBB);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'hCC;
    resetn       = 1'b1;
    #1;
    check_now("midreset", 0, 0, 0, 2'd0, 5'd0, 32'h0, 16'd0, 16'd0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    resetn       = 1'b0;
    settle();
    @(negedge clk);
    send_frame(KIND_INST, 5'd1, 32'h0BADF00D, M_OK, -1, 0);
    check_now("post_reset", 1, 0, 0, KIND_INST, 5'd1, 32'h0BADF00D, 16'd1, 16'd0);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
